// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

  // Segment pattern with every segment dark (active-low bus)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Level of a single anode line when its digit is switched off (active-low)
  localparam logic ANODE_OFF = 1'b1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Width needed to count 0 .. div-1, never less than one bit
  function automatic int slot_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bcd_decoder.sv
// BCD to active-low seven-segment decoder (bit6 = g .. bit0 = a).
// Nibbles above 9 produce a dark digit.
module bcd_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup from nibble to segment pattern
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scan_slot_timer.sv
// Free-running digit slot timer. Each slot is REFRESH_DIV cycles long;
// blank_end marks the last dead-time cycle, slot_end the last cycle of the slot.
module scan_slot_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  output logic blank_end,
  output logic slot_end
);

  localparam int CW = slot_cnt_width(REFRESH_DIV);

  logic [CW-1:0] cnt;

  assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));

  // Count through the slot and wrap back to zero so slots follow back to back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexes NUM_DIGITS BCD digits onto one common-anode seven-segment bus.
// Every slot starts with all anodes off (anti-ghosting) before the digit is shown.
// New digit values are double buffered and only switch in at frame boundaries.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    slot_blank;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] active;

  logic                    blank_end;
  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              cur_digit;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic                    lz_hit;

  scan_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .blank_end(blank_end),
    .slot_end (slot_end)
  );

  // The one decoder on the board is shared by all digits through the idx mux
  bcd_decoder u_decoder (
    .bcd(cur_digit),
    .seg(dec_seg)
  );

  assign frame_end = (state == ST_SHOW) && slot_end && (idx == LAST_IDX);

  // Select the current digit, its anode, and whether it is a leading zero
  always_comb begin
    cur_digit = 4'd0;
    an_sel    = {NUM_DIGITS{ANODE_OFF}};
    lz_hit    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = active[4*i +: 4];
        an_sel[i] = ~ANODE_OFF;
      end
      if ((IDX_W'(i) >= idx) && (active[4*i +: 4] != 4'd0)) begin
        lz_hit = 1'b0;
      end
    end
    if (idx == '0) begin
      lz_hit = 1'b0;
    end
  end

  // Capture loads into pending; promote to active only when a frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (frame_end) begin
        active <= load ? digits_in : pending;
      end
      if (load) begin
        pending <= digits_in;
      end
    end
  end

  // Scan FSM stepping BLANK/SHOW per slot, with outputs registered one cycle behind state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BLANK;
      idx        <= '0;
      slot_blank <= 1'b0;
      an_out     <= {NUM_DIGITS{ANODE_OFF}};
      seg_out    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      if ((state == ST_SHOW) && !slot_blank) begin
        an_out  <= an_sel;
        seg_out <= dec_seg;
      end else begin
        an_out  <= {NUM_DIGITS{ANODE_OFF}};
        seg_out <= SEG_BLANK;
      end
      frame_done <= frame_end;

      case (state)
        ST_BLANK: begin
          if (blank_end) begin
            state      <= ST_SHOW;
            slot_blank <= blank_lz && lz_hit;
          end
        end
        ST_SHOW: begin
          if (slot_end) begin
            state <= ST_BLANK;
            idx   <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller with 4 digits, 8-cycle slots, 2 dead cycles.
module tb_seg_scan_controller;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   digits_in = 16'h0000;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [6:0]    seg_out;
  logic [3:0]    an_out;
  logic          frame_done;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .frame_done(frame_done)
  );

  int total = 0;
  int bad = 0;

  // Reference model: time position since reset release plus frame-level buffers
  int          e = 0;
  logic [15:0] m_act = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  logic        m_lz = 1'b0;

  typedef struct {
    logic [15:0] din;
    logic        lz;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [6:0] decode_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Index of the most significant non-zero digit (0 when the value is zero)
  function automatic int top_nonzero(input logic [15:0] v);
    int h = 0;
    for (int i = 0; i < ND; i++) begin
      if (v[4*i +: 4] != 4'd0) h = i;
    end
    return h;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, actual, expected, e);
    end
  endtask

  // One clock: predict the outputs for this edge, then compare just after it
  task automatic tick();
    int p, s, off;
    logic show;
    logic [3:0] ea;
    logic [6:0] es;
    logic ef;
    @(posedge clk);
    e++;
    p   = e - 1;
    s   = (p / RD) % ND;
    off = p % RD;
    show = (off >= BC) && !(m_lz && (s > top_nonzero(m_act)));
    ea = show ? ~(4'b0001 << s) : 4'b1111;
    es = show ? decode_ref(m_act[4*s +: 4]) : 7'h7F;
    ef = ((p % FRAME) == FRAME - 1);
    if (off == BC - 1) m_lz = blank_lz;
    if ((p % FRAME) == FRAME - 1) m_act = load ? digits_in : m_pend;
    if (load) m_pend = digits_in;
    #1;
    checkOutput("an_out", {28'd0, an_out}, {28'd0, ea});
    checkOutput("seg_out", {25'd0, seg_out}, {25'd0, es});
    checkOutput("frame_done", {31'd0, frame_done}, {31'd0, ef});
  endtask

  task automatic applyStimulus(input logic [15:0] din, input logic lz);
    digits_in = din;
    blank_lz  = lz;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  // Advance until the cycle just observed is the given position within a frame
  task automatic runToPos(input int target);
    bit hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      tick();
      if (((e - 1) % FRAME) == target) hit = 1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("[TB] FAIL runToPos: position %0d not reached, at %0d", target, (e - 1) % FRAME);
    end
  endtask

  initial begin
    bit seen;

    vecs[0]  = '{16'h1234, 1'b0, 0, 4'b1110, 7'b0011001};
    vecs[1]  = '{16'h1234, 1'b0, 3, 4'b0111, 7'b1111001};
    vecs[2]  = '{16'h1234, 1'b0, 1, 4'b1101, 7'b0110000};
    vecs[3]  = '{16'h0050, 1'b1, 3, 4'b1111, 7'h7F};
    vecs[4]  = '{16'h0050, 1'b1, 2, 4'b1111, 7'h7F};
    vecs[5]  = '{16'h0050, 1'b1, 1, 4'b1101, 7'b0010010};
    vecs[6]  = '{16'h0050, 1'b1, 0, 4'b1110, 7'b1000000};
    vecs[7]  = '{16'h0000, 1'b1, 0, 4'b1110, 7'b1000000};
    vecs[8]  = '{16'h0000, 1'b1, 1, 4'b1111, 7'h7F};
    vecs[9]  = '{16'h00A7, 1'b0, 1, 4'b1101, 7'h7F};
    vecs[10] = '{16'h00A7, 1'b0, 0, 4'b1110, 7'b1111000};
    vecs[11] = '{16'h2222, 1'b0, 2, 4'b1011, 7'b0100100};

    // Asynchronous reset values appear without a clock edge
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset an_out", {28'd0, an_out}, 32'h0000000F);
    checkOutput("reset seg_out", {25'd0, seg_out}, 32'h0000007F);
    checkOutput("reset frame_done", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First frame_done after release lands on edge FRAME
    seen = 0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tick();
      if (frame_done) seen = 1;
    end
    checkOutput("first frame_done edge", e, FRAME);

    // Table of load / blanking cases checked in the following frame
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].din, vecs[i].lz);
      runToPos(FRAME - 1);
      runToPos(vecs[i].slot * RD + 4);
      checkOutput($sformatf("vec%0d an_out", i), {28'd0, an_out}, {28'd0, vecs[i].an});
      checkOutput($sformatf("vec%0d seg_out", i), {25'd0, seg_out}, {25'd0, vecs[i].seg});
    end

    // Mid-frame loads leave the current frame alone; the last one wins next frame
    applyStimulus(16'h9999, 1'b0);
    runToPos(FRAME - 1);
    runToPos(5);
    applyStimulus(16'h1111, 1'b0);
    runToPos(12);
    applyStimulus(16'h2222, 1'b0);
    runToPos(28);
    checkOutput("midframe hold seg", {25'd0, seg_out}, 32'h10);
    checkOutput("midframe hold an", {28'd0, an_out}, 32'h7);
    runToPos(FRAME - 1);
    runToPos(4);
    checkOutput("last load wins seg", {25'd0, seg_out}, 32'h24);
    checkOutput("last load wins an", {28'd0, an_out}, 32'hE);

    // Load on the boundary edge goes straight into the next frame
    runToPos(FRAME - 2);
    digits_in = 16'h5555;
    load = 1'b1;
    tick();
    load = 1'b0;
    runToPos(4);
    checkOutput("boundary load seg", {25'd0, seg_out}, 32'h12);

    // Reset in the middle of slot 2's show time
    runToPos(2 * RD + 4);
    checkOutput("pre-reset an slot2", {28'd0, an_out}, 32'hB);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midshow reset an_out", {28'd0, an_out}, 32'h0000000F);
    checkOutput("midshow reset seg_out", {25'd0, seg_out}, 32'h0000007F);
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    m_act = 16'h0000;
    m_pend = 16'h0000;
    m_lz = 1'b0;
    runToPos(4);
    checkOutput("restart slot0 an", {28'd0, an_out}, 32'hE);
    checkOutput("restart slot0 seg", {25'd0, seg_out}, 32'h40);

    // Random loads and blanking changes against the model
    for (int i = 0; i < 800; i++) begin
      logic [15:0] v;
      for (int n = 0; n < ND; n++) begin
        v[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      digits_in = v;
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      tick();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
